// File: rtl/rv32i_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state
// encoding, opcode constants, and the layout/encodings of the decode bundle.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_MULDIV = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Decode bundle width and field LSB offsets (MSB-first packing below)
    localparam int CTRL_W             = 26;
    localparam int CTRL_ALU1SRC_LSB   = 25;
    localparam int CTRL_ALU2SRC_LSB   = 24;
    localparam int CTRL_IMMTYPE_LSB   = 21;
    localparam int CTRL_ALUTYPE_LSB   = 19;
    localparam int CTRL_ADTYPE_LSB    = 18;
    localparam int CTRL_GATYPE_LSB    = 16;
    localparam int CTRL_SHIFTYPE_LSB  = 14;
    localparam int CTRL_SLTYPE_LSB    = 13;
    localparam int CTRL_RDTYPE_LSB    = 11;
    localparam int CTRL_LOADTYPE_LSB  = 8;
    localparam int CTRL_STORE_LSB     = 7;
    localparam int CTRL_STORETYPE_LSB = 5;
    localparam int CTRL_BRANCH_LSB    = 4;
    localparam int CTRL_BRTYPE_LSB    = 1;
    localparam int CTRL_JUMP_LSB      = 0;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // ALU unit select
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_GATE  = 2'd1;
    localparam logic [1:0] ALU_SHIFT = 2'd2;
    localparam logic [1:0] ALU_SLT   = 2'd3;

    // Logic gate select
    localparam logic [1:0] GATE_AND = 2'd0;
    localparam logic [1:0] GATE_OR  = 2'd1;
    localparam logic [1:0] GATE_XOR = 2'd2;

    // Shifter select
    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    // Register-file write source
    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_MEM = 2'd1;
    localparam logic [1:0] RD_PC4 = 2'd2;
    localparam logic [1:0] RD_IMM = 2'd3;

    typedef struct packed {
        logic       alu1src;    // 0: rs1, 1: PC
        logic       alu2src;    // 0: rs2, 1: immediate
        logic [2:0] immtype;
        logic [1:0] alutype;
        logic       adtype;     // 0: add, 1: subtract
        logic [1:0] gatype;
        logic [1:0] shiftype;
        logic       sltype;     // 0: signed, 1: unsigned compare
        logic [1:0] rdtype;
        logic [2:0] loadtype;   // funct3 of the load
        logic       store;
        logic [1:0] storetype;  // funct3[1:0] of the store
        logic       branch;
        logic [2:0] branchtype; // funct3 of the branch
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(26'd0);

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    endfunction

    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // ALU-class control for OP / OP-IMM; alt selects SUB or SRA(I)
    function automatic ctrl_t alu_ctrl(input logic [2:0] f3, input logic alt,
                                       input logic use_imm);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu2src = use_imm;
        c.immtype = IMM_I;
        c.rdtype  = RD_ALU;
        case (f3)
            3'b000: begin c.alutype = ALU_ADD;   c.adtype   = alt;    end
            3'b001: begin c.alutype = ALU_SHIFT; c.shiftype = SH_SLL; end
            3'b010: begin c.alutype = ALU_SLT;   c.sltype   = 1'b0;   end
            3'b011: begin c.alutype = ALU_SLT;   c.sltype   = 1'b1;   end
            3'b100: begin c.alutype = ALU_GATE;  c.gatype   = GATE_XOR; end
            3'b101: begin c.alutype = ALU_SHIFT; c.shiftype = alt ? SH_SRA : SH_SRL; end
            3'b110: begin c.alutype = ALU_GATE;  c.gatype   = GATE_OR;  end
            3'b111: begin c.alutype = ALU_GATE;  c.gatype   = GATE_AND; end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle,
// mul/div operation code and an illegal-instruction flag.
import rv32i_pkg::*;

module rv32i_decoder #(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [2:0]  md_op_o,
    output logic        is_md_o,
    output logic        illegal_o
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_fields_s;

    assign opcode_s = instr_i[6:0];
    assign funct3_s = instr_i[14:12];
    assign funct7_s = instr_i[31:25];
    // Register and immediate fields do not influence control decode
    assign unused_fields_s = ^{instr_i[24:15], instr_i[11:7]};

    // Decode opcode/funct fields into the control bundle and legality
    always_comb begin
        ctrl_o    = CTRL_NOP;
        md_op_o   = 3'd0;
        is_md_o   = 1'b0;
        illegal_o = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                if (funct7_s == F7_MULDIV) begin
                    if (ENABLE_M) begin
                        is_md_o = 1'b1;
                        md_op_o = funct3_s;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else if ((funct7_s == F7_BASE) ||
                             ((funct7_s == F7_ALT) &&
                              ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
                    ctrl_o = alu_ctrl(funct3_s, funct7_s[5], 1'b0);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (funct3_s == 3'b001) begin
                    if (funct7_s == F7_BASE) begin
                        ctrl_o = alu_ctrl(funct3_s, 1'b0, 1'b1);
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else if (funct3_s == 3'b101) begin
                    if ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) begin
                        ctrl_o = alu_ctrl(funct3_s, funct7_s[5], 1'b1);
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else begin
                    // ADDI never subtracts, so funct7 bits are immediate here
                    ctrl_o = alu_ctrl(funct3_s, 1'b0, 1'b1);
                end
            end
            OPC_LOAD: begin
                if (load_f3_ok(funct3_s)) begin
                    ctrl_o.alu2src  = 1'b1;
                    ctrl_o.immtype  = IMM_I;
                    ctrl_o.rdtype   = RD_MEM;
                    ctrl_o.loadtype = funct3_s;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_STORE: begin
                if (store_f3_ok(funct3_s)) begin
                    ctrl_o.alu2src   = 1'b1;
                    ctrl_o.immtype   = IMM_S;
                    ctrl_o.store     = 1'b1;
                    ctrl_o.storetype = funct3_s[1:0];
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (branch_f3_ok(funct3_s)) begin
                    ctrl_o.immtype    = IMM_B;
                    ctrl_o.adtype     = 1'b1;
                    ctrl_o.branch     = 1'b1;
                    ctrl_o.branchtype = funct3_s;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_JAL: begin
                ctrl_o.alu1src = 1'b1;
                ctrl_o.alu2src = 1'b1;
                ctrl_o.immtype = IMM_J;
                ctrl_o.rdtype  = RD_PC4;
                ctrl_o.jump    = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.alu2src = 1'b1;
                ctrl_o.immtype = IMM_I;
                ctrl_o.rdtype  = RD_PC4;
                ctrl_o.jump    = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o.alu2src = 1'b1;
                ctrl_o.immtype = IMM_U;
                ctrl_o.rdtype  = RD_IMM;
            end
            OPC_AUIPC: begin
                ctrl_o.alu1src = 1'b1;
                ctrl_o.alu2src = 1'b1;
                ctrl_o.immtype = IMM_U;
                ctrl_o.rdtype  = RD_ALU;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_fsm_rv32i_mc.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// mul-div/write-back, guards memory waits with a timeout and latches faults.
import rv32i_pkg::*;

module ctrl_fsm_rv32i_mc #(
    parameter bit          ENABLE_M    = 1'b0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        md_done,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        md_start,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [25:0] ctrl,
    output logic [2:0]  md_op,
    output logic        illegal,
    output logic        bus_fault,
    output logic [2:0]  state_o
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [2:0]  md_op_q, md_op_d;
    logic        is_md_q, is_md_d;
    logic        md_busy_q, md_busy_d;
    logic        illegal_q, illegal_d;
    logic        bus_fault_q, bus_fault_d;

    ctrl_t       dec_ctrl_s;
    logic [2:0]  dec_md_op_s;
    logic        dec_is_md_s;
    logic        dec_illegal_s;

    logic        waiting_s;
    logic        ready_s;
    logic [7:0]  wait_inc_s;
    logic        timeout_s;
    logic        is_ldst_s;

    // Decode from the internally captured instruction so instr need only be
    // valid while imem_ready is high
    rv32i_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_decoder (
        .instr_i   (ir_q),
        .ctrl_o    (dec_ctrl_s),
        .md_op_o   (dec_md_op_s),
        .is_md_o   (dec_is_md_s),
        .illegal_o (dec_illegal_s)
    );

    assign waiting_s  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ready_s    = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
    assign wait_inc_s = wait_cnt_q + 8'd1;
    // A ready arriving on the limit cycle wins over the timeout
    assign timeout_s  = waiting_s && !ready_s && (wait_inc_s == TIMEOUT_C);
    assign is_ldst_s  = (ctrl_q.rdtype == RD_MEM) || ctrl_q.store;

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            wait_cnt_q  <= 8'd0;
            ir_q        <= 32'd0;
            ctrl_q      <= CTRL_NOP;
            md_op_q     <= 3'd0;
            is_md_q     <= 1'b0;
            md_busy_q   <= 1'b0;
            illegal_q   <= 1'b0;
            bus_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ir_q        <= ir_d;
            ctrl_q      <= ctrl_d;
            md_op_q     <= md_op_d;
            is_md_q     <= is_md_d;
            md_busy_q   <= md_busy_d;
            illegal_q   <= illegal_d;
            bus_fault_q <= bus_fault_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_ldst_s) begin
                    state_d = ST_MEM;
                end else if (is_md_q) begin
                    state_d = ST_MULDIV;
                end else if (ctrl_q.branch) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = ctrl_q.store ? ST_FETCH : ST_WB;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MULDIV: begin
                if (md_done) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MULDIV;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Next values for wait counter, instruction/decode latches and fault flags
    always_comb begin
        ir_d        = ir_q;
        ctrl_d      = ctrl_q;
        md_op_d     = md_op_q;
        is_md_d     = is_md_q;
        illegal_d   = illegal_q;
        bus_fault_d = bus_fault_q;
        md_busy_d   = (state_q == ST_MULDIV);
        // Counter only runs while a memory wait is outstanding, so it is
        // already zero on every entry to FETCH or MEM
        if (waiting_s && !ready_s) begin
            wait_cnt_d = wait_inc_s;
        end else begin
            wait_cnt_d = 8'd0;
        end
        if (timeout_s) begin
            bus_fault_d = 1'b1;
        end else begin
            bus_fault_d = bus_fault_q;
        end
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_d = instr;
                end else begin
                    ir_d = ir_q;
                end
            end
            ST_DECODE: begin
                ctrl_d  = dec_ctrl_s;
                md_op_d = dec_md_op_s;
                is_md_d = dec_is_md_s;
                if (dec_illegal_s) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            default: begin
                ir_d = ir_q;
            end
        endcase
    end

    // Request and write strobes decoded from the current state
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        md_start = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        if (rst) begin
            imem_req = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_EXEC: begin
                    pc_we = ctrl_q.branch;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    pc_we    = dmem_ready && ctrl_q.store;
                end
                ST_MULDIV: begin
                    md_start = !md_busy_q;
                end
                ST_WB: begin
                    pc_we = 1'b1;
                    // x0 is never written, but the PC still advances
                    rf_we = (ir_q[11:7] != 5'd0);
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    assign ctrl      = ctrl_q;
    assign md_op     = md_op_q;
    assign illegal   = illegal_q;
    assign bus_fault = bus_fault_q;
    assign state_o   = state_q;

endmodule

// File: doc/ctrl_fsm_rv32i_mc.md
CTRL_FSM_RV32I_MC -- requirements
Module: ctrl_fsm_rv32i_mc

Interface
REQ-001 The block SHALL have the parameter ENABLE_M, default 0, meaning 1 enables RV32M decode and the multiply/divide handshake.
REQ-002 The block SHALL have the parameter MEM_TIMEOUT, default 15, range 1..255, meaning the maximum wait cycles for imem/dmem ready before a bus fault.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port instr, input, 32 bits: the instruction word from instruction memory, valid when imem_ready is high.
REQ-006 The block SHALL have the ports imem_ready, dmem_ready and md_done, inputs, 1 bit each: memory and mul/div completion strobes.
REQ-007 The block SHALL have the ports imem_req, dmem_req, md_start, ir_we, pc_we and rf_we, outputs, 1 bit each: the request and write strobes.
REQ-008 The block SHALL have the port ctrl, output, 26 bits: the registered decode bundle {ALU1src, ALU2src, immtype[2:0], ALUtype[1:0], adtype, gatype[1:0], shiftype[1:0], sltype, rdtype[1:0], loadtype[2:0], store, storetype[1:0], branch, branchtype[2:0], jump}, with field encodings per the rv32i control-encoding table.
REQ-009 The block SHALL have the port md_op, output, 3 bits: funct3 of the M instruction; it is 0 when ENABLE_M=0.
REQ-010 The block SHALL have the ports illegal and bus_fault, outputs, 1 bit each: sticky fault flags.
REQ-011 The block SHALL have the port state_o, output, 3 bits: the current FSM state, for debug.

Function
REQ-012 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, MULDIV=4, WB=5 and HALT=6.
REQ-013 In FETCH, imem_req SHALL be 1; when imem_ready=1, ir_we SHALL pulse for 1 cycle and the FSM SHALL go to DECODE.
REQ-014 In DECODE, the FSM SHALL latch ctrl from instr in one cycle and then go to EXEC; illegal opcode/funct combinations SHALL go to HALT with illegal=1.
REQ-015 Legal opcodes SHALL be 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37 and 0x17. Illegal cases are: undefined funct3 in load/store/branch; funct7 other than 0x00/0x20 on R-type and shift-immediates; 0x20 only on ADD/SRL/SRA; funct7=0x01 with ENABLE_M=0.
REQ-016 From EXEC, the next state SHALL be:
- MEM for load/store;
- MULDIV for an M instruction;
- WB for R/I/LUI/AUIPC/JAL/JALR;
- FETCH with pc_we=1 for branches.
REQ-017 In MEM, dmem_req SHALL be held at 1 until dmem_ready. When dmem_ready arrives, a load SHALL go to WB and a store SHALL go to FETCH with pc_we=1.
REQ-018 In MULDIV, md_start SHALL pulse exactly in the first cycle. The FSM SHALL then wait for md_done (no timeout) and go to WB.
REQ-019 WB SHALL assert rf_we and pc_we for exactly 1 cycle, then go to FETCH.
REQ-020 rf_we SHALL never assert when instr[11:7]=0; pc_we SHALL still assert.
REQ-021 The wait counter SHALL be 8 bits, cleared on entry to FETCH or MEM, and incremented each cycle the ready signal is low.
REQ-022 When the counter equals MEM_TIMEOUT with ready still low, the FSM SHALL go to HALT with bus_fault=1 and all requests deasserted.
REQ-023 A ready signal arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL win, with no fault raised.
REQ-024 HALT SHALL be absorbing until rst; in HALT all strobes are 0 and ctrl holds its value.
REQ-025 imem_ready/dmem_ready outside FETCH/MEM, and md_done outside MULDIV, SHALL be ignored.

Reset
REQ-026 When rst is asserted, the FSM SHALL go to FETCH on the next edge.
REQ-027 On reset, ctrl, md_op, the counter, illegal and bus_fault SHALL be 0, and all strobes SHALL be 0 in the reset cycle.
REQ-028 A reset in any state, including mid-MEM or mid-MULDIV, SHALL abandon the operation with no rf_we/pc_we pulse.
REQ-029 imem_req SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 The state encoding, opcode constants, and ctrl field widths/offsets and encodings SHALL live in the shared package rv32i_pkg.
REQ-031 The combinational decoder SHALL be the sub-module rv32i_decoder (instr -> ctrl, md_op, illegal_dec), instantiated once; the FSM and counter SHALL live in the top module.

Verification
REQ-032 The bench SHALL cover ADDI: instr=0x00500093, imem_ready=1 -> FETCH,DECODE,EXEC,WB; rf_we=1 and pc_we=1 in cycle 4; total 4 cycles.
REQ-033 The bench SHALL cover LW with dmem_ready asserted 3 cycles late: instr=0x0000A103 -> dmem_req high 4 cycles, loadtype=010, rdtype=01; then WB, rf_we=1.
REQ-034 The bench SHALL cover the timeout at MEM_TIMEOUT=4: imem_ready held 0 -> HALT after 4 wait cycles with bus_fault=1 and imem_req=0 thereafter; a variant with ready in cycle 4 raises no fault.
REQ-035 The bench SHALL cover MUL with ENABLE_M=1: instr=0x022081B3 -> md_start pulses once and md_op=000; md_done after 10 cycles -> WB. The same instr with ENABLE_M=0 -> HALT with illegal=1.
REQ-036 The bench SHALL cover BEQ: instr=0x00208463 -> branch=1, branchtype=000, immtype=010; pc_we in EXEC; rf_we never asserted.
REQ-037 The bench SHALL cover reset in MEM: rst pulsed while dmem_req=1 -> next state FETCH with ctrl=0, no rf_we, no pc_we.
